// File: rtl/rf_wb_arbiter_if.sv
// Writeback request, register-file write and decode bypass signals shared
// between the ALU/LSU writeback stages, the arbiter and reg_file/decode.
interface rf_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) ();

  logic              alu_wb_valid;
  logic [ADDR_W-1:0] alu_wb_rd;
  logic [DATA_W-1:0] alu_wb_data;
  logic              alu_wb_ready;

  logic              lsu_wb_valid;
  logic [ADDR_W-1:0] lsu_wb_rd;
  logic [DATA_W-1:0] lsu_wb_data;
  logic              lsu_wb_ready;

  logic              reg_wr_en;
  logic [ADDR_W-1:0] write_reg1;
  logic [DATA_W-1:0] write_data;

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data;

  // Requesters, reg_file and decode side
  modport master (
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  alu_wb_ready,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    input  lsu_wb_ready,
    input  reg_wr_en, write_reg1, write_data,
    output rd_addr1, rd_addr2,
    input  fwd_hit1, fwd_hit2, fwd_data
  );

  // Arbiter side
  modport slave (
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    output alu_wb_ready,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    output lsu_wb_ready,
    output reg_wr_en, write_reg1, write_data,
    input  rd_addr1, rd_addr2,
    output fwd_hit1, fwd_hit2, fwd_data
  );

endinterface

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU/LSU writebacks onto the single reg_file write port:
// LSU priority with an ALU anti-starvation counter, registered write, bypass.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic               clock,
  input  logic               reset,
  rf_wb_arbiter_if.slave     wb
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              reg_wr_en_q,  reg_wr_en_d;
  logic [ADDR_W-1:0] write_reg1_q, write_reg1_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic alu_grant_c;
  logic lsu_grant_c;
  logic alu_forced_c;

  // Grant: LSU wins ties unless the ALU has lost STARVE_LIMIT cycles in a row
  always_comb begin
    alu_grant_c  = 1'b0;
    lsu_grant_c  = 1'b0;
    alu_forced_c = (starve_cnt_q == CNT_MAX);
    if (!reset) begin
      if (wb.alu_wb_valid && wb.lsu_wb_valid) begin
        alu_grant_c = alu_forced_c;
        lsu_grant_c = !alu_forced_c;
      end else begin
        alu_grant_c = wb.alu_wb_valid;
        lsu_grant_c = wb.lsu_wb_valid;
      end
    end
  end

  assign wb.alu_wb_ready = alu_grant_c;
  assign wb.lsu_wb_ready = lsu_grant_c;

  // Next state: starvation count and the winner's write; x0 writes complete but never enable
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    reg_wr_en_d  = 1'b0;
    write_reg1_d = write_reg1_q;
    write_data_d = write_data_q;

    if (!wb.alu_wb_valid || alu_grant_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    if (alu_grant_c) begin
      write_reg1_d = wb.alu_wb_rd;
      write_data_d = wb.alu_wb_data;
      reg_wr_en_d  = (wb.alu_wb_rd != '0);
    end else if (lsu_grant_c) begin
      write_reg1_d = wb.lsu_wb_rd;
      write_data_d = wb.lsu_wb_data;
      reg_wr_en_d  = (wb.lsu_wb_rd != '0);
    end
  end

  // Reset drops any in-flight write and clears the starvation history
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
      reg_wr_en_q  <= 1'b0;
      write_reg1_q <= '0;
      write_data_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      reg_wr_en_q  <= reg_wr_en_d;
      write_reg1_q <= write_reg1_d;
      write_data_q <= write_data_d;
    end
  end

  assign wb.reg_wr_en  = reg_wr_en_q;
  assign wb.write_reg1 = write_reg1_q;
  assign wb.write_data = write_data_q;

  // Bypass the value reg_file will commit at the next edge; x0 never forwards
  assign wb.fwd_hit1 = reg_wr_en_q && (write_reg1_q == wb.rd_addr1) && (wb.rd_addr1 != '0);
  assign wb.fwd_hit2 = reg_wr_en_q && (write_reg1_q == wb.rd_addr2) && (wb.rd_addr2 != '0);
  assign wb.fwd_data = write_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios followed by random
// ALU/LSU traffic with occasional resets, checked against a reference model.
module tb_rf_wb_arbiter;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned STARVE_LIMIT = 3;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } txn_t;

  typedef struct {
    int                cyc;
    bit                en;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

  rf_wb_arbiter #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wb   (wb.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   rst_s  = 1'b1;
  txn_t alu_q[$];
  txn_t lsu_q[$];
  exp_t exp_q[$];
  int   alu_losses = 0;
  bit   rst_sched  = 1'b1;
  int   pin1 = -1;
  int   pin2 = -1;
  bit   dut_win[$];
  logic [DATA_W-1:0] rf_dut [32];

  always #5 clock = ~clock;

  // Cycle count, reset as sampled by the DUT, and a reg_file fed by the DUT outputs
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
    if (wb.reg_wr_en) rf_dut[wb.write_reg1] <= wb.write_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_alu(input int rd, input logic [DATA_W-1:0] d);
    txn_t t;
    t.rd = ADDR_W'(rd);
    t.data = d;
    alu_q.push_back(t);
  endtask

  task automatic push_lsu(input int rd, input logic [DATA_W-1:0] d);
    txn_t t;
    t.rd = ADDR_W'(rd);
    t.data = d;
    lsu_q.push_back(t);
  endtask

  // Present queue heads; requests stay stable until their grant pops them
  task automatic drive();
    reset = rst_sched;
    if (alu_q.size() > 0) begin
      wb.alu_wb_valid = 1'b1;
      wb.alu_wb_rd    = alu_q[0].rd;
      wb.alu_wb_data  = alu_q[0].data;
    end else begin
      wb.alu_wb_valid = 1'b0;
      wb.alu_wb_rd    = ADDR_W'($urandom);
      wb.alu_wb_data  = $urandom;
    end
    if (lsu_q.size() > 0) begin
      wb.lsu_wb_valid = 1'b1;
      wb.lsu_wb_rd    = lsu_q[0].rd;
      wb.lsu_wb_data  = lsu_q[0].data;
    end else begin
      wb.lsu_wb_valid = 1'b0;
      wb.lsu_wb_rd    = ADDR_W'($urandom);
      wb.lsu_wb_data  = $urandom;
    end
    wb.rd_addr1 = (pin1 >= 0) ? ADDR_W'(pin1) : ADDR_W'($urandom_range(0, 7));
    wb.rd_addr2 = (pin2 >= 0) ? ADDR_W'(pin2) : ADDR_W'($urandom_range(0, 7));
  endtask

  // One cycle: predict the grant from the priority rules, check readys, queue the expected write
  task automatic step();
    bit   av, lv, ea, el;
    txn_t t;
    exp_t e;
    @(negedge clock);
    av = wb.alu_wb_valid;
    lv = wb.lsu_wb_valid;
    if (reset) begin
      ea = 1'b0;
      el = 1'b0;
    end else if (av && lv) begin
      ea = (alu_losses >= int'(STARVE_LIMIT));
      el = !ea;
    end else begin
      ea = av;
      el = lv;
    end
    chk("alu_wb_ready", 32'(wb.alu_wb_ready), 32'(ea));
    chk("lsu_wb_ready", 32'(wb.lsu_wb_ready), 32'(el));
    if (wb.alu_wb_ready || wb.lsu_wb_ready) dut_win.push_back(wb.alu_wb_ready);
    if (reset || !av || ea) alu_losses = 0;
    else alu_losses++;
    if (ea || el) begin
      t = ea ? alu_q.pop_front() : lsu_q.pop_front();
      e.cyc  = cyc + 1;
      e.en   = (t.rd != '0);
      e.rd   = t.rd;
      e.data = t.data;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    drive();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((alu_q.size() > 0 || lsu_q.size() > 0) && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(alu_q.size() + lsu_q.size()), 32'd0);
    repeat (3) step();
  endtask

  // Monitor: output register, hold behaviour and bypass against the scoreboard
  initial begin
    exp_t              e;
    bit                e_en;
    logic [ADDR_W-1:0] h_rd   = '0;
    logic [DATA_W-1:0] h_data = '0;
    bit                h1, h2;
    forever begin
      @(negedge clock);
      e_en = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e      = exp_q.pop_front();
        e_en   = e.en;
        h_rd   = e.rd;
        h_data = e.data;
      end
      if (rst_s) begin
        e_en   = 1'b0;
        h_rd   = '0;
        h_data = '0;
      end
      h1 = e_en && (h_rd == wb.rd_addr1) && (wb.rd_addr1 != '0);
      h2 = e_en && (h_rd == wb.rd_addr2) && (wb.rd_addr2 != '0);
      chk("reg_wr_en",  32'(wb.reg_wr_en),  32'(e_en));
      chk("write_reg1", 32'(wb.write_reg1), 32'(h_rd));
      chk("write_data", wb.write_data,      h_data);
      chk("fwd_hit1",   32'(wb.fwd_hit1),   32'(h1));
      chk("fwd_hit2",   32'(wb.fwd_hit2),   32'(h2));
      chk("fwd_data",   wb.fwd_data,        h_data);
    end
  end

  initial begin
    logic [9:0] pat = 10'b0001000100;

    // Reset held with both requesters valid, then LSU wins first
    push_alu(3, $urandom);
    push_lsu(4, $urandom);
    drive();
    step();
    rst_sched = 1'b0;
    step();
    drain("reset_drain");

    // Single ALU write with decode reading the same register
    push_alu(5, 32'hDEADBEEF);
    pin1 = 5;
    drive();
    drain("alu_single_drain");
    pin1 = -1;

    // Continuous contention: three LSU wins, then a forced ALU win
    dut_win.delete();
    for (int i = 1; i <= 8; i++) push_lsu(i, $urandom);
    push_alu(20, $urandom);
    push_alu(21, $urandom);
    drive();
    drain("starve_drain");
    chk("starve_grants", 32'(dut_win.size()), 32'd10);
    for (int i = 0; i < 10; i++) chk("starve_order", 32'(dut_win[i]), 32'(pat[9-i]));

    // Write to x0 completes but does not enable or forward
    push_lsu(0, 32'h1234);
    pin1 = 0;
    pin2 = 0;
    drive();
    drain("x0_drain");
    pin1 = -1;
    pin2 = -1;

    // Same destination from both: grant order decides the final value
    push_lsu(7, 32'hA);
    push_alu(7, 32'hB);
    pin2 = 7;
    drive();
    drain("same_rd_drain");
    pin2 = -1;
    chk("x7_last_write", rf_dut[7], 32'hB);

    // Reset while a write is in flight and the ALU has been losing
    for (int i = 10; i < 16; i++) push_lsu(i, $urandom);
    push_alu(9, $urandom);
    drive();
    step();
    step();
    rst_sched = 1'b1;
    step();
    step();
    rst_sched = 1'b0;
    drain("mid_reset_drain");

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 40 && alu_q.size() < 3)
        push_alu(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 99) < 50 && lsu_q.size() < 3)
        push_lsu(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)), $urandom);
      rst_sched = rst_sched ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0);
      drive();
      step();
    end
    rst_sched = 1'b0;
    drive();
    drain("random_drain");
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
